// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the 16-bit pipelined CPU. Owns the PC, requests
// instructions from a variable-latency instruction memory, and writes the
// IF/ID pipeline register. A one-entry hold buffer and a drop state make sure
// that no instruction is lost or duplicated across stalls or branch redirects.
//
// Ports:
//   clk, rst        : clock; synchronous active-high reset
//   pc_write        : hazard unit, 0 = freeze PC
//   ifid_write      : hazard unit, 0 = hold IF/ID contents
//   if_flush        : ID-stage taken branch, redirect to br_target and squash
//   br_target       : redirect address (valid with if_flush)
//   imem_req        : fetch request to instruction memory
//   imem_addr       : word address of the request
//   imem_ready      : memory accepts and returns data this cycle
//   imem_rdata      : instruction data (valid with imem_req & imem_ready)
//   ifid_instr      : IF/ID instruction
//   ifid_pc_plus1   : IF/ID address of that instruction plus 1
//   ifid_valid      : IF/ID 1 = real instruction, 0 = bubble
//   pc              : current fetch PC
//   dbg_state       : current FSM state (FETCH=0, HELD=1, DROP=2)
//
// Handshake: while imem_req=1, imem_addr stays stable until a cycle with
// imem_ready=1; the transfer completes in that cycle and nothing is left
// outstanding afterwards.
// ============================================================================
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        if_flush,
    input  logic [15:0] br_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus1,
    output logic        ifid_valid,
    output logic [15:0] pc,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,  // request outstanding at pc
        HELD  = 2'd1,  // instruction captured in hold_buf, waiting for stall release
        DROP  = 2'd2   // request at drop_addr must complete, its data is discarded
    } state_t;

    state_t      state, state_n;
    logic [15:0] hold_buf, hold_buf_n;
    logic [15:0] drop_addr, drop_addr_n;
    logic [15:0] pc_n;
    logic [15:0] ifid_instr_n;
    logic [15:0] ifid_pc_plus1_n;
    logic        ifid_valid_n;
    logic [15:0] pc_inc;
    logic        advance;

    // pc_write=0 with ifid_write=1 is never produced by the hazard unit;
    // treating it as a stall keeps PC and IF/ID consistent.
    assign advance = pc_write & ifid_write;
    assign pc_inc  = pc + 16'd1;

    // Outputs decoded from state and registers only; imem_rdata never reaches
    // an output combinationally.
    assign imem_req  = ~rst & (state != HELD);
    assign imem_addr = (state == DROP) ? drop_addr : pc;
    assign dbg_state = state;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus1 <= 16'h0000;
            ifid_valid    <= 1'b0;
            hold_buf      <= 16'h0000;
            drop_addr     <= 16'h0000;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            ifid_instr    <= ifid_instr_n;
            ifid_pc_plus1 <= ifid_pc_plus1_n;
            ifid_valid    <= ifid_valid_n;
            hold_buf      <= hold_buf_n;
            drop_addr     <= drop_addr_n;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_n         = state;
        pc_n            = pc;
        ifid_instr_n    = ifid_instr;
        ifid_pc_plus1_n = ifid_pc_plus1;
        ifid_valid_n    = ifid_valid;
        hold_buf_n      = hold_buf;
        drop_addr_n     = drop_addr;

        case (state)
            FETCH: begin
                if (if_flush) begin
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    pc_n         = br_target;
                    if (!imem_ready) begin
                        // The request at the old pc cannot be withdrawn; finish
                        // it at the old address and throw its data away.
                        drop_addr_n = pc;
                        state_n     = DROP;
                    end
                end else if (imem_ready) begin
                    if (advance) begin
                        ifid_instr_n    = imem_rdata;
                        ifid_pc_plus1_n = pc_inc;
                        ifid_valid_n    = 1'b1;
                        pc_n            = pc_inc;
                    end else begin
                        // Data arrived during a stall; park it so it is not
                        // fetched a second time.
                        hold_buf_n = imem_rdata;
                        state_n    = HELD;
                    end
                end else if (ifid_write) begin
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                end
            end

            HELD: begin
                if (if_flush) begin
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    pc_n         = br_target;
                    state_n      = FETCH;
                end else if (advance) begin
                    ifid_instr_n    = hold_buf;
                    ifid_pc_plus1_n = pc_inc;
                    ifid_valid_n    = 1'b1;
                    pc_n            = pc_inc;
                    state_n         = FETCH;
                end
            end

            DROP: begin
                if (ifid_write || if_flush) begin
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                end
                if (if_flush) begin
                    pc_n = br_target;
                end
                if (imem_ready) begin
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage
// Directed cycle vectors for if_fetch_stage. Each vector gives the inputs for
// one cycle and the outputs expected during that cycle (imem_req/imem_addr
// from the current state, IF/ID and pc as left by the previous edge).
// ============================================================================
module tb_if_fetch_stage;

    localparam int W = 66;  // {req, addr, instr, pc_plus1, valid, pc}

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        ifid_write;
    logic        if_flush;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic [15:0] pc;
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;

    if_fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .if_flush      (if_flush),
        .br_target     (br_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid),
        .pc            (pc),
        .dbg_state     (dbg_state)
    );

    // Memory model: every word holds its address XOR 16'hA5A5.
    assign imem_rdata = imem_addr ^ 16'hA5A5;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // ------------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Driver: apply one cycle of inputs just after a rising edge and queue the
    // outputs expected during that cycle.
    // ------------------------------------------------------------------------
    task automatic cyc(input logic r, input logic pw, input logic iw,
                       input logic fl, input logic [15:0] tgt, input logic rdy,
                       input logic ereq, input logic [15:0] eaddr,
                       input logic [15:0] einstr, input logic [15:0] epp1,
                       input logic ev, input logic [15:0] epc);
        rst        = r;
        pc_write   = pw;
        ifid_write = iw;
        if_flush   = fl;
        br_target  = tgt;
        imem_ready = rdy;
        exp_q.push_back({ereq, eaddr, einstr, epp1, ev, epc});
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard: mid-cycle, pop one expectation and compare.
    // ------------------------------------------------------------------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("imem_req", {15'd0, imem_req}, {15'd0, e[65]});
                if (e[65])
                    chk("imem_addr", imem_addr, e[64:49]);
                chk("ifid_instr", ifid_instr, e[48:33]);
                chk("ifid_pc_plus1", ifid_pc_plus1, e[32:17]);
                chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, e[16]});
                chk("pc", pc, e[15:0]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if_flush   = 1'b0;
        br_target  = 16'h0000;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        //   rst pw iw fl tgt       rdy | req addr      instr              pp1       v  pc
        // Reset state, request suppressed while rst=1
        cyc(1, 1, 1, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000,         16'h0000, 0, 16'h0000);
        // Zero-wait streaming
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0000, 16'h0000,         16'h0000, 0, 16'h0000);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0001, mem(16'h0000),    16'h0001, 1, 16'h0001);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0002, mem(16'h0001),    16'h0002, 1, 16'h0002);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0003, mem(16'h0002),    16'h0003, 1, 16'h0003);
        // Three wait cycles at addr 4 -> three bubbles
        cyc(0, 1, 1, 0, 16'h0000, 0,   1, 16'h0004, mem(16'h0003),    16'h0004, 1, 16'h0004);
        cyc(0, 1, 1, 0, 16'h0000, 0,   1, 16'h0004, 16'h0000,         16'h0004, 0, 16'h0004);
        cyc(0, 1, 1, 0, 16'h0000, 0,   1, 16'h0004, 16'h0000,         16'h0004, 0, 16'h0004);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0004, 16'h0000,         16'h0004, 0, 16'h0004);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0005, mem(16'h0004),    16'h0005, 1, 16'h0005);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0006, mem(16'h0005),    16'h0006, 1, 16'h0006);
        // Stall exactly as addr 7 returns -> HELD for two cycles
        cyc(0, 0, 0, 0, 16'h0000, 1,   1, 16'h0007, mem(16'h0006),    16'h0007, 1, 16'h0007);
        cyc(0, 0, 0, 0, 16'h0000, 1,   0, 16'h0007, mem(16'h0006),    16'h0007, 1, 16'h0007);
        cyc(0, 0, 0, 0, 16'h0000, 1,   0, 16'h0007, mem(16'h0006),    16'h0007, 1, 16'h0007);
        cyc(0, 1, 1, 0, 16'h0000, 1,   0, 16'h0007, mem(16'h0006),    16'h0007, 1, 16'h0007);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0008, mem(16'h0007),    16'h0008, 1, 16'h0008);
        // Flush while addr 9 is waiting -> DROP holds addr 9, then 0x0040
        cyc(0, 1, 1, 0, 16'h0000, 0,   1, 16'h0009, mem(16'h0008),    16'h0009, 1, 16'h0009);
        cyc(0, 1, 1, 1, 16'h0040, 0,   1, 16'h0009, 16'h0000,         16'h0009, 0, 16'h0009);
        cyc(0, 1, 1, 0, 16'h0000, 0,   1, 16'h0009, 16'h0000,         16'h0009, 0, 16'h0040);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0009, 16'h0000,         16'h0009, 0, 16'h0040);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0040, 16'h0000,         16'h0009, 0, 16'h0040);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0041, mem(16'h0040),    16'h0041, 1, 16'h0041);
        // Flush during HELD with both stall controls low
        cyc(0, 0, 0, 0, 16'h0000, 1,   1, 16'h0042, mem(16'h0041),    16'h0042, 1, 16'h0042);
        cyc(0, 0, 0, 1, 16'h0100, 1,   0, 16'h0042, mem(16'h0041),    16'h0042, 1, 16'h0042);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0100, 16'h0000,         16'h0042, 0, 16'h0100);
        // Flush with ready=1 to 16'hFFFF, then PC wrap
        cyc(0, 1, 1, 1, 16'hFFFF, 1,   1, 16'h0101, mem(16'h0100),    16'h0101, 1, 16'h0101);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'hFFFF, 16'h0000,         16'h0101, 0, 16'hFFFF);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0000, mem(16'hFFFF),    16'h0000, 1, 16'h0000);
        // Reset in the middle of DROP
        cyc(0, 1, 1, 1, 16'h0200, 0,   1, 16'h0001, mem(16'h0000),    16'h0001, 1, 16'h0001);
        cyc(0, 1, 1, 0, 16'h0000, 0,   1, 16'h0001, 16'h0000,         16'h0001, 0, 16'h0200);
        cyc(1, 1, 1, 0, 16'h0000, 0,   0, 16'h0001, 16'h0000,         16'h0001, 0, 16'h0200);
        cyc(1, 1, 1, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000,         16'h0000, 0, 16'h0000);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0000, 16'h0000,         16'h0000, 0, 16'h0000);
        // pc_write=0 with ifid_write=1 is a stall: instruction parked, not lost
        cyc(0, 0, 1, 0, 16'h0000, 1,   1, 16'h0001, mem(16'h0000),    16'h0001, 1, 16'h0001);
        cyc(0, 1, 1, 0, 16'h0000, 1,   0, 16'h0001, mem(16'h0000),    16'h0001, 1, 16'h0001);
        cyc(0, 1, 1, 0, 16'h0000, 1,   1, 16'h0002, mem(16'h0001),    16'h0002, 1, 16'h0002);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
